rc4_ksa: RTL
============

# rc4_ksa

RC4 key-scheduling stage that feeds the RC4 byte-stream (PRGA) engine. It captures a 1–32 byte key streamed over `key_valid`/`key_in`, initialises a 256×8 state array S to the identity permutation, and runs the 256-step KSA permutation. After completion it raises `ksa_done` and hands S to the downstream keystream stage through a single read/write access port.

## Interface
- `MAX_KEY`, 32: maximum key length in bytes; extra bytes are ignored.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `key_valid`  in  1  key byte present on `key_in` this cycle.
- `key_in`  in  8  key byte.
- `busy`  out  1  high in LOAD, INIT, KSA.
- `ksa_done`  out  1  S holds the scheduled permutation; level, held until reset or new key.
- `key_len`  out  6  number of key bytes captured (1..32).
- `s_addr`  in  8  downstream S index.
- `s_we`  in  1  write `s_wdata` to S[`s_addr`]; honoured only while `ksa_done`=1.
- `s_wdata`  in  8  write data.
- `s_rdata`  out  8  registered S[`s_addr`]; 1-cycle read latency.

## Operation
- States: IDLE, LOAD, INIT, KSA, DONE.
- IDLE: on an edge with `key_valid`=1, capture `key_in` into K[0], set `key_len`=1, go to LOAD.
- LOAD: each edge with `key_valid`=1 stores `key_in` at K[`key_len`] and increments `key_len`. If `key_len`=32, bytes are dropped and `key_len` saturates. The first edge with `key_valid`=0 moves to INIT.
- INIT: one edge writes S[n]=n for all n, clears i, j and key index k to 0, and moves to KSA.
- KSA: one swap per edge.
  - j' = (j + S[i] + K[k]) mod 256, 8-bit wraparound add.
  - Swap S[i] and S[j'], then j←j'.
  - k←(k = `key_len`−1) ? 0 : k+1. There is no divider.
  - i←i+1.
  - When i=j' the swap is a no-op and S is unchanged.
  - After the i=255 swap, go to DONE.
- DONE: `ksa_done`=1. The access port is active.
  - `s_we`=1 writes S[`s_addr`] at the edge.
  - `s_rdata` takes S[`s_addr`] at every edge. A read and a write to the same address on the same edge return the old value.
- DONE with `key_valid`=1: clear `ksa_done`, capture the byte as K[0] with `key_len`=1, and enter LOAD (rekey).
- `key_valid` in INIT or KSA is ignored.
- `s_we` outside DONE is ignored.
- `s_rdata`=0 outside DONE.

## Timing
- Reset values: state=IDLE, `busy`=0, `ksa_done`=0, `key_len`=0, `s_rdata`=0, i=j=k=0. K and S contents are don't-care until INIT.
- Reset asserted in any state aborts the operation by the next edge, with no partial `ksa_done`.
- Let edge E0 be the first edge sampling `key_valid`=0 in LOAD. Then:
  - state=INIT after E0;
  - state=KSA after E0+1;
  - the swaps occur at E0+2..E0+257;
  - `ksa_done`=1 and `busy`=0 after E0+257.
- Total latency is 257 cycles after key end, independent of key length.
- `busy` and `ksa_done` are never both high.
- Read path: `s_addr` is presented before edge n, and `s_rdata` is valid after edge n.

## Test plan
- Reset mid-KSA: assert `rst` at E0+100 for 1 cycle → after the next edge `busy`=0, `ksa_done`=0, `key_len`=0. A fresh key then completes normally.
- Key "Key" (4B 65 79), then one PRGA step driven by the bench through the port → output byte 0xEB.
  - PRGA step: i=1, read S[1] into j, swap, read S[(S[1]+S[j]) mod 256].
  - `key_len`=3.
  - `ksa_done` rises exactly 257 cycles after E0.
- 1-byte key 0x00 and 32-byte key 00..1F → all 256 S entries read back match a software KSA model; the entries form a permutation.
- 40-byte key stream → `key_len`=32 and S matches the model for the first 32 bytes only.
- Port check in DONE: write S[5]=0xA5 and read S[5] on the same edge → old value; the next read → 0xA5.
  - `s_we` pulsed during KSA leaves S matching the model.
- Rekey from DONE: second key "Wiki" → `ksa_done` drops on the first key edge, rises 257 cycles after its E0, and S matches the model for "Wiki".

Source files
------------

// File: rtl/rc4_ksa.sv
// RC4 key-scheduling stage: captures a streamed key and builds the 256-entry permutation S.
// When scheduling finishes, S is handed to the keystream stage through a one-port read/write interface.
module rc4_ksa #(
    parameter int MAX_KEY = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_in,
    output logic       busy,
    output logic       ksa_done,
    output logic [5:0] key_len,
    input  logic [7:0] s_addr,
    input  logic       s_we,
    input  logic [7:0] s_wdata,
    output logic [7:0] s_rdata
);

    localparam int KW = (MAX_KEY > 1) ? $clog2(MAX_KEY) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, INIT, KSA, DONE} state_t;

    state_t          state_q, state_d;
    logic [5:0]      key_len_q, key_len_d;
    logic [7:0]      i_q, i_d;
    logic [7:0]      j_q, j_d;
    logic [KW-1:0]   k_q, k_d;
    logic [7:0]      s_rdata_q;

    logic [7:0]      key_q [MAX_KEY];
    logic [7:0]      s_q   [256];

    logic            key_we;
    logic [KW-1:0]   key_widx;
    logic [7:0]      s_i, s_j, j_new;

    // NOTE: always_comb assigns every output a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        key_len_d = key_len_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        key_we    = 1'b0;
        key_widx  = '0;
        s_i       = s_q[i_q];
        j_new     = j_q + s_i + key_q[k_q];
        s_j       = s_q[j_new];

        case (state_q)
            IDLE, DONE: begin
                if (key_valid) begin
                    key_we    = 1'b1;
                    key_len_d = 6'd1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (key_valid) begin
                    if (key_len_q < 6'(MAX_KEY)) begin
                        key_we    = 1'b1;
                        key_widx  = key_len_q[KW-1:0];
                        key_len_d = key_len_q + 6'd1;
                    end
                end else begin
                    state_d = INIT;
                end
            end
            INIT: begin
                i_d     = '0;
                j_d     = '0;
                k_d     = '0;
                state_d = KSA;
            end
            KSA: begin
                j_d = j_new;
                // Wrap the key index by comparison so no modulo/divider is needed.
                k_d = (6'(k_q) == key_len_q - 6'd1) ? '0 : k_q + 1'b1;
                i_d = i_q + 8'd1;
                if (i_q == 8'd255) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            key_len_q <= '0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
        end else begin
            state_q   <= state_d;
            key_len_q <= key_len_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
        end
    end

    // NOTE: key and S storage carry no reset; their contents are rebuilt before use.
    always_ff @(posedge clk) begin
        if (!rst && key_we) key_q[key_widx] <= key_in;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT) begin
                for (int n = 0; n < 256; n++) s_q[n] <= 8'(n);
            end else if (state_q == KSA) begin
                // When i == j' both writes carry the same value, so the swap degenerates cleanly.
                s_q[i_q]  <= s_j;
                s_q[j_new] <= s_i;
            end else if (state_q == DONE && s_we) begin
                s_q[s_addr] <= s_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state_q != DONE) s_rdata_q <= '0;
        else                        s_rdata_q <= s_q[s_addr];
    end

    assign busy     = (state_q == LOAD) || (state_q == INIT) || (state_q == KSA);
    assign ksa_done = (state_q == DONE);
    assign key_len  = key_len_q;
    assign s_rdata  = ksa_done ? s_rdata_q : 8'h00;

endmodule
